mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
- Multi-cycle multiply/divide unit. It sits beside the combinational alu in EX and consumes the same srcA/srcB operand pair.
- It holds the architectural HI/LO registers.
- It returns results after a fixed, parameterised latency.
- It raises busy so the hazard unit can stall mult/div/mfhi/mflo/mthi/mtlo behind it.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, cycles busy stays high for div/divu (legal range 1..15)

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request; md_op, srcA and srcB are sampled on the same edge
- md_op  input  3  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
- srcA  input  32  rs operand (dividend / multiplicand / mthi-mtlo source)
- srcB  input  32  rt operand (divisor / multiplier)
- busy  output  1  registered; high while a mult/div is in flight
- HI  output  32  HI register (registered, read directly by mfhi)
- LO  output  32  LO register (registered, read directly by mflo)

Behaviour:
- Interface is fixed: one clock; asynchronous active-low reset rst_n.
- rst_n low forces the following immediately, independent of clk, including mid-operation:
  - state to IDLE, counter to 0, busy to 0, HI to 0, LO to 0.
  - Any in-flight result is discarded.
- FSM, IDLE state:
  - On an edge with start=1 and md_op in {1,2,3,4}:
    - Compute the result combinationally from the sampled operands and latch it into shadow registers.
    - Load the counter with N-1, where N is MULT_CYCLES for mult/multu and DIV_CYCLES for div/divu.
    - Set busy=1 and go to RUN.
  - On an edge with start=1 and md_op=5: HI<=srcA. With md_op=6: LO<=srcA. No busy, stay in IDLE.
  - start=1 with md_op 0 or 7 is a no-op.
- FSM, RUN state:
  - Each edge decrements the counter.
  - On the edge where the counter is 0: commit shadow to HI/LO, busy<=0, return to IDLE.
- Latency: if start is sampled at edge E, busy is high from E to E+N, and new HI/LO are visible after edge E+N.
- HI/LO hold their old values throughout RUN.
- start during RUN is ignored, whatever md_op is; the stall logic prevents it, and the block does not queue it.
- mult: signed 32x32 to 64-bit product; HI=[63:32], LO=[31:0].
- multu: the same operation, unsigned.
- div: signed division.
  - LO = quotient, truncated toward zero.
  - HI = remainder, carrying the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned division; LO = quotient, HI = remainder.
- Divide by zero (div or divu, srcB=0): still busy for DIV_CYCLES, then HI/LO are left unchanged (the commit is suppressed).
- No X propagation: shadow registers reset to 0.

Test Plan:
- Reset, then mult srcA=0xFFFFFFFE (-2), srcB=3: busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; HI/LO unchanged while busy.
- multu srcA=0xFFFFFFFF, srcB=2: after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- div srcA=0xFFFFFFF9 (-7), srcB=2: busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu srcA=200, srcB=0 with prior HI=0x11, LO=0x22: busy for 10 cycles; HI/LO stay 0x11/0x22.
  - Follow with div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi srcA=0xDEADBEEF then mtlo srcA=0x12345678 on back-to-back cycles: busy never rises; HI/LO updated one edge after each.
  - Then start mult during RUN with different operands: ignored; the first result commits.
- Start div 100/7, deassert rst_n asynchronously at cycle 4 of RUN: busy, HI and LO go to 0 immediately.
  - After rst_n returns high, a fresh multu 200*200 gives LO=40000, HI=0 after 5 cycles.

Source files
------------

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are computed at issue and committed after a fixed latency.
module mdu_seq #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_busy, w_busy_nxt;
  logic [31:0] r_hi, w_hi_nxt;
  logic [31:0] r_lo, w_lo_nxt;
  logic [31:0] r_sh_hi, w_sh_hi_nxt;
  logic [31:0] r_sh_lo, w_sh_lo_nxt;
  logic        r_sh_commit, w_sh_commit_nxt;

  logic [63:0] w_prod_s, w_prod_u, w_prod;
  logic        w_a_neg, w_b_neg;
  logic [31:0] w_a_mag, w_b_mag, w_uq, w_ur, w_quo, w_rem;

  // Sign-extending to 64 bits makes the low half of an unsigned multiply
  // equal to the two's-complement signed product.
  assign w_prod_s = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
  assign w_prod_u = {32'd0, srcA} * {32'd0, srcB};
  assign w_prod   = (md_op == OP_MULTU) ? w_prod_u : w_prod_s;

  // One unsigned divider serves both forms; div works on magnitudes and
  // restores signs so the quotient truncates toward zero.
  assign w_a_neg = (md_op == OP_DIV) && srcA[31];
  assign w_b_neg = (md_op == OP_DIV) && srcB[31];
  assign w_a_mag = w_a_neg ? -srcA : srcA;
  assign w_b_mag = w_b_neg ? -srcB : srcB;
  assign w_uq    = (w_b_mag == 32'd0) ? 32'd0 : w_a_mag / w_b_mag;
  assign w_ur    = (w_b_mag == 32'd0) ? 32'd0 : w_a_mag % w_b_mag;
  assign w_quo   = (w_a_neg ^ w_b_neg) ? -w_uq : w_uq;
  assign w_rem   = w_a_neg ? -w_ur : w_ur;

  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_busy_nxt      = r_busy;
    w_hi_nxt        = r_hi;
    w_lo_nxt        = r_lo;
    w_sh_hi_nxt     = r_sh_hi;
    w_sh_lo_nxt     = r_sh_lo;
    w_sh_commit_nxt = r_sh_commit;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT, OP_MULTU: begin
              w_sh_hi_nxt     = w_prod[63:32];
              w_sh_lo_nxt     = w_prod[31:0];
              w_sh_commit_nxt = 1'b1;
              w_cnt_nxt       = MULT_LOAD;
              w_busy_nxt      = 1'b1;
              w_state_nxt     = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              w_sh_hi_nxt     = w_rem;
              w_sh_lo_nxt     = w_quo;
              w_sh_commit_nxt = (srcB != 32'd0);
              w_cnt_nxt       = DIV_LOAD;
              w_busy_nxt      = 1'b1;
              w_state_nxt     = S_RUN;
            end
            OP_MTHI: w_hi_nxt = srcA;
            OP_MTLO: w_lo_nxt = srcA;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (r_cnt == 4'd0) begin
          if (r_sh_commit) begin
            w_hi_nxt = r_sh_hi;
            w_lo_nxt = r_sh_lo;
          end
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_busy      <= 1'b0;
      r_hi        <= 32'd0;
      r_lo        <= 32'd0;
      // NOTE: shadow registers are reset too so nothing undefined can ever commit.
      r_sh_hi     <= 32'd0;
      r_sh_lo     <= 32'd0;
      r_sh_commit <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_busy      <= w_busy_nxt;
      r_hi        <= w_hi_nxt;
      r_lo        <= w_lo_nxt;
      r_sh_hi     <= w_sh_hi_nxt;
      r_sh_lo     <= w_sh_lo_nxt;
      r_sh_commit <= w_sh_commit_nxt;
    end
  end

  assign busy = r_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: issued ops push expectations from an
// arithmetic reference model; a monitor checks them when busy falls.
module tb_mdu_seq;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] srcA, srcB;
  logic        busy;
  logic [31:0] HI, LO;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;
    int          cycles;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_hi, model_lo;
  int          checks   = 0;
  int          failures = 0;

  mdu_seq #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op),
    .srcA(srcA), .srcB(srcB), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural behaviour written directly with 64-bit arithmetic.
  function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    inout logic [31:0] hi, inout logic [31:0] lo);
    longint          p, q, r;
    longint unsigned pu;
    case (op)
      3'd1: begin
        p  = longint'($signed(a)) * longint'($signed(b));
        hi = p[63:32];
        lo = p[31:0];
      end
      3'd2: begin
        pu = 64'(a) * 64'(b);
        hi = pu[63:32];
        lo = pu[31:0];
      end
      3'd3: if (b != 0) begin
        q  = longint'($signed(a)) / longint'($signed(b));
        r  = longint'($signed(a)) % longint'($signed(b));
        lo = q[31:0];
        hi = r[31:0];
      end
      3'd4: if (b != 0) begin
        lo = a / b;
        hi = a % b;
      end
      3'd5: hi = a;
      3'd6: lo = a;
      default: ;
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the sampling edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [31:0] nh, nl;
    start = 1'b1; md_op = op; srcA = a; srcB = b;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    nh = model_hi; nl = model_lo;
    ref_model(op, a, b, nh, nl);
    if (op inside {3'd1, 3'd2, 3'd3, 3'd4}) begin
      e.hi = nh; e.lo = nl; e.prev_hi = model_hi; e.prev_lo = model_lo;
      e.cycles = (op <= 3'd2) ? MULT_N : DIV_N;
      sb_q.push_back(e);
      check("busy_rise", 32'(busy), 32'd1);
    end else begin
      check("busy_idle", 32'(busy), 32'd0);
      check("hi_direct", HI, nh);
      check("lo_direct", LO, nl);
    end
    model_hi = nh; model_lo = nl;
  endtask

  // A start while RUN must be ignored entirely.
  task automatic inject(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; srcA = a; srcB = b;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    check("busy_after_inject", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (busy === 1'b1 && n < max_cycles) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy !== 1'b0) check("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  // Monitor: counts busy cycles and checks hold/commit against the queue head.
  initial begin
    int   cnt;
    exp_t e;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt = 0;
      end else if (busy) begin
        cnt++;
        if (sb_q.size() == 0) begin
          check("busy_unexpected", 32'(busy), 32'd0);
        end else begin
          check("hi_hold", HI, sb_q[0].prev_hi);
          check("lo_hold", LO, sb_q[0].prev_lo);
        end
      end else if (cnt > 0) begin
        if (sb_q.size() == 0) begin
          check("result_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("busy_cycles", 32'(cnt), 32'(e.cycles));
          check("hi_commit", HI, e.hi);
          check("lo_commit", LO, e.lo);
        end
        cnt = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; md_op = 3'd0; srcA = '0; srcB = '0;
    model_hi = '0; model_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    rst_n = 1'b1;

    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    wait_idle(20);
    @(posedge clk); #1;
    check("tp_mult_hi", HI, 32'hFFFF_FFFF);
    check("tp_mult_lo", LO, 32'hFFFF_FFFA);

    issue(3'd2, 32'hFFFF_FFFF, 32'd2);
    wait_idle(20);
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(20);
    @(posedge clk); #1;
    check("tp_div_hi", HI, 32'hFFFF_FFFF);
    check("tp_div_lo", LO, 32'hFFFF_FFFD);

    issue(3'd5, 32'h11, 32'd0);
    issue(3'd6, 32'h22, 32'd0);
    issue(3'd4, 32'd200, 32'd0);
    wait_idle(20);
    @(posedge clk); #1;
    check("tp_div0_hi", HI, 32'h11);
    check("tp_div0_lo", LO, 32'h22);

    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(20);
    @(posedge clk); #1;
    check("tp_ovf_hi", HI, 32'd0);
    check("tp_ovf_lo", LO, 32'h8000_0000);

    issue(3'd5, 32'hDEAD_BEEF, 32'd0);
    issue(3'd6, 32'h1234_5678, 32'd0);
    issue(3'd1, 32'd6, 32'd7);
    inject(3'd1, 32'd1000, 32'd1000);
    inject(3'd5, 32'hAAAA_AAAA, 32'd0);
    wait_idle(20);
    @(posedge clk); #1;
    check("tp_ignore_lo", LO, 32'd42);

    // Asynchronous reset in the middle of a divide.
    issue(3'd3, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_hi", HI, 32'd0);
    check("async_rst_lo", LO, 32'd0);
    sb_q.delete();
    model_hi = '0; model_lo = '0;
    @(negedge clk);
    @(posedge clk); #1;
    check("rst_hold_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    issue(3'd2, 32'd200, 32'd200);
    wait_idle(20);
    @(posedge clk); #1;
    check("tp_post_rst_hi", HI, 32'd0);
    check("tp_post_rst_lo", LO, 32'd40000);

    for (int i = 0; i < 60; i++) begin
      automatic logic [2:0]  op = 3'($urandom_range(0, 7));
      automatic logic [31:0] a  = $urandom;
      automatic logic [31:0] b  = $urandom;
      if ($urandom_range(0, 4) == 0) b = 32'd0;
      if ($urandom_range(0, 4) == 0) b = 32'($urandom_range(1, 9));
      if (op == 3'd3 && $urandom_range(0, 5) == 0) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      issue(op, a, b);
      if (op inside {3'd1, 3'd2, 3'd3, 3'd4}) begin
        if ($urandom_range(0, 1) == 1) begin
          repeat ($urandom_range(0, MULT_N - 3)) begin
            @(posedge clk); #1;
          end
          inject(3'($urandom_range(0, 7)), $urandom, $urandom);
        end
        wait_idle(20);
      end
    end

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
